verificador_aleatorio: RTL and testbench
========================================

# verificador_aleatorio

Receive-side checker for the 3-bit pseudo-random stream produced by `generador_aleatorio`. It samples values on a valid strobe, predicts each next value with the same LFSR step, and locks once the stream is self-consistent. It then flags mismatches and drops lock after repeated errors. It sits downstream of the generator, or of any block forwarding its values, and gives game logic and benches a single "stream healthy" indication.

## Interface
- `WIDTH`, 3: sample width; must equal the package LFSR width.
- `LOCK_COUNT`, 4: consecutive correct predictions required to enter LOCKED (range 1–15).
- `LOSS_COUNT`, 2: consecutive mispredictions in LOCKED that force re-search (range 1–15).
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `valid`, input, 1: `data` is a new sample this cycle.
- `data`, input, WIDTH: sampled random value.
- `locked`, output, 1: checker is in LOCKED.
- `error`, output, 1: one-cycle pulse for a misprediction while LOCKED.
- `zero_err`, output, 1: one-cycle pulse when a valid sample equals 0 (LFSR lock-up value).
- `err_count`, output, 16: saturating count of `error` pulses.
- `sample_count`, output, 16: saturating count of valid samples.

## Operation
- Next-state function, from the package: `next(x) = {x[1:0], x[2]^x[1]}`.
- Full sequence from 3: 3,7,6,4,1,2,5,3 (period 7, nonzero values only).
- Internal registers: `ref` (last reference value), `good` and `bad` (4-bit run counters), state.
- States: IDLE, SEARCH, LOCKED. All updates occur only when `valid`=1; with `valid`=0 every register holds.
- **IDLE**
  - Nonzero sample: `ref`←data, `good`←0, go to SEARCH.
  - Zero sample: stay in IDLE and pulse `zero_err`.
- **SEARCH**
  - `data==next(ref)`: `good`++ and `ref`←data. When `good` reaches LOCK_COUNT, go to LOCKED with `bad`←0.
  - Mismatch, nonzero: `ref`←data, `good`←0 (reseed).
  - Zero sample: pulse `zero_err`, go to IDLE.
- **LOCKED**
  - Match: `ref`←data, `bad`←0.
  - Mismatch, including zero:
    - Pulse `error` and increment `bad`.
    - Flywheel: `ref`←next(ref), so prediction continues along the expected sequence.
    - When `bad` reaches LOSS_COUNT, go to SEARCH with `ref`←data, `good`←0. If data is 0, go to IDLE instead.
  - A zero sample also pulses `zero_err`, simultaneously with `error`.
- Counters saturate at 16'hFFFF and never wrap.

## Timing
- All outputs are registered.
- Reset values:
  - `locked`=0, `error`=0, `zero_err`=0, `err_count`=0, `sample_count`=0.
  - state=IDLE, `ref`=0, `good`=0, `bad`=0.
- `error` and `zero_err` assert in the cycle after the offending valid sample, for exactly one cycle.
- `locked` rises in the cycle after the sample that completes LOCK_COUNT matches. It falls in the cycle after the LOSS_COUNT-th consecutive miss.
- From the first sample, minimum lock latency is LOCK_COUNT+1 valid samples.
- Back-to-back valid samples are supported every cycle; there is no backpressure.
- `rst` overrides `valid` in the same cycle. Reset mid-LOCKED clears everything on the next edge.

## Configuration
- Macro: `VERIFICADOR_STATS_EN`.
- Defined: `err_count` and `sample_count` are implemented as described.
- Undefined: both ports are tied to constant 0 and the counter logic is absent. `locked`, `error` and `zero_err` are unaffected.

## Structure
- Package `aleatorio_pkg` holds:
  - the `LFSR_WIDTH` constant (3);
  - the `lfsr_next` function;
  - the `estado_verif_t` enum (IDLE, SEARCH, LOCKED).
- `generador_aleatorio` should import the same package so both ends share one polynomial.
- One sub-module: `contador_saturado` (16-bit, synchronous reset, enable, saturating), instantiated twice under the macro.

## Test plan
- **Lock:** after reset, valid each cycle with 3,7,6,4,1 → `locked`=1 the cycle after the 1 sample; `error` never pulses; `sample_count`=5.
- **Single error:** in LOCKED, feed 2 then 6 where 5 is expected → `error` pulses once, `err_count`=1, `locked` stays 1. Then feed 3 (flywheel expects 3) → no error, `bad` cleared.
- **Loss of lock:** in LOCKED with `ref`=4, feed 7 then 7 → two `error` pulses and `locked`=0 after the second. Then 6,4,1,2,5 → `locked`=1 again.
- **Zero:** valid `data`=0 in each state → `zero_err` pulses each time; in LOCKED `error` also pulses; SEARCH returns to IDLE.
- **Valid gaps:** during the lock sequence, drop `valid` for 3 cycles between samples → identical result to the back-to-back case, and counters do not advance during the gaps.
- **Reset mid-operation:** assert `rst` for one cycle while LOCKED with `err_count`=2 → next cycle all outputs 0 and state IDLE, even with `valid`=1 during reset.

Source files
------------

// File: rtl/aleatorio_pkg.sv
// Shared definitions for the pseudo-random generator/checker pair.
// Both ends import this package, so they use the same LFSR polynomial.
package aleatorio_pkg;

  localparam int unsigned LFSR_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } estado_verif_t;

  // One LFSR step. Zero is the lock-up value and maps to itself.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] x);
    return {x[1:0], x[2] ^ x[1]};
  endfunction

endpackage

// File: rtl/contador_saturado.sv
// 16-bit up-counter with synchronous reset and enable; it sticks at all-ones.
module contador_saturado (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/verificador_aleatorio.sv
// Receive-side checker for the 3-bit LFSR stream: locks on a self-consistent stream.
// Optional statistics counters are built only when VERIFICADOR_STATS_EN is defined.
module verificador_aleatorio
  import aleatorio_pkg::*;
#(
  parameter int unsigned WIDTH      = 3,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  output logic             locked,
  output logic             error,
  output logic             zero_err,
  output logic [15:0]      err_count,
  output logic [15:0]      sample_count
);

  estado_verif_t        state_q, state_d;
  logic [WIDTH-1:0]     ref_q, ref_d;
  logic [3:0]           good_q, good_d;
  logic [3:0]           bad_q, bad_d;
  logic                 locked_q;
  logic                 error_q, error_d;
  logic                 zero_q, zero_d;
  logic [WIDTH-1:0]     predicted;

  assign predicted = lfsr_next(ref_q);

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    good_d  = good_q;
    bad_d   = bad_q;
    error_d = 1'b0;
    zero_d  = 1'b0;
    if (valid) begin
      case (state_q)
        IDLE: begin
          if (data == '0) begin
            zero_d = 1'b1;
          end else begin
            ref_d   = data;
            good_d  = 4'd0;
            state_d = SEARCH;
          end
        end
        SEARCH: begin
          if (data == '0) begin
            zero_d  = 1'b1;
            state_d = IDLE;
          end else if (data == predicted) begin
            ref_d  = data;
            good_d = good_q + 4'd1;
            if (good_d == 4'(LOCK_COUNT)) begin
              state_d = LOCKED;
              bad_d   = 4'd0;
            end
          end else begin
            ref_d  = data;
            good_d = 4'd0;
          end
        end
        LOCKED: begin
          if (data == predicted) begin
            ref_d = data;
            bad_d = 4'd0;
          end else begin
            // Flywheel: keep predicting along the expected sequence through misses.
            error_d = 1'b1;
            zero_d  = (data == '0);
            bad_d   = bad_q + 4'd1;
            ref_d   = predicted;
            if (bad_d == 4'(LOSS_COUNT)) begin
              good_d = 4'd0;
              if (data == '0) begin
                state_d = IDLE;
              end else begin
                state_d = SEARCH;
                ref_d   = data;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ref_q    <= '0;
      good_q   <= 4'd0;
      bad_q    <= 4'd0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      locked_q <= (state_d == LOCKED);
      error_q  <= error_d;
      zero_q   <= zero_d;
    end
  end

  assign locked   = locked_q;
  assign error    = error_q;
  assign zero_err = zero_q;

`ifdef VERIFICADOR_STATS_EN
  // Counters advance on the same edge that registers the error pulse / sample.
  contador_saturado u_err_count (
    .clk     (clk),
    .rst     (rst),
    .en_i    (error_d),
    .count_o (err_count)
  );

  contador_saturado u_sample_count (
    .clk     (clk),
    .rst     (rst),
    .en_i    (valid),
    .count_o (sample_count)
  );
`else
  assign err_count    = 16'd0;
  assign sample_count = 16'd0;
`endif

endmodule

// File: tb/tb_verificador_aleatorio.sv
// Self-checking bench for verificador_aleatorio: vector table through a scoreboard queue,
// plus a lock-latency sweep over every nonzero seed.
module tb_verificador_aleatorio;

  localparam int LOCK_COUNT = 4;
`ifdef VERIFICADOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [2:0]  data;
  logic        locked;
  logic        error;
  logic        zero_err;
  logic [15:0] err_count;
  logic [15:0] sample_count;

  always #5 clk = ~clk;

  verificador_aleatorio #(
    .WIDTH      (3),
    .LOCK_COUNT (LOCK_COUNT),
    .LOSS_COUNT (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid        (valid),
    .data         (data),
    .locked       (locked),
    .error        (error),
    .zero_err     (zero_err),
    .err_count    (err_count),
    .sample_count (sample_count)
  );

  typedef struct {
    logic       rst;
    logic       valid;
    logic [2:0] data;
    logic       locked;
    logic       error;
    logic       zero;
    int         ec;
    int         sc;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [2:0] model_next(input logic [2:0] x);
    return {x[1:0], x[2] ^ x[1]};
  endfunction

  task automatic add(input logic r, input logic v, input logic [2:0] d,
                     input logic l, input logic e, input logic z,
                     input int ec, input int sc);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d;
    t.locked = l; t.error = e; t.zero = z;
    t.ec = STATS ? ec : 0;
    t.sc = STATS ? sc : 0;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [2:0] d);
    @(negedge clk);
    rst = r; valid = v; data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t exp_v;
    int   n;
    logic [2:0] x;

    rst = 1'b1; valid = 1'b0; data = 3'd0;

    // reset (rst overrides valid)
    add(1,0,0, 0,0,0, 0,0);
    add(1,1,3, 0,0,0, 0,0);
    // lock on 3,7,6,4,1
    add(0,1,3, 0,0,0, 0,1);
    add(0,1,7, 0,0,0, 0,2);
    add(0,1,6, 0,0,0, 0,3);
    add(0,1,4, 0,0,0, 0,4);
    add(0,1,1, 1,0,0, 0,5);
    // single error, then flywheel match clears bad
    add(0,1,2, 1,0,0, 0,6);
    add(0,1,6, 1,1,0, 1,7);
    add(0,1,3, 1,0,0, 1,8);
    add(0,1,7, 1,0,0, 1,9);
    add(0,1,6, 1,0,0, 1,10);
    add(0,1,4, 1,0,0, 1,11);
    // loss of lock with ref=4, then relock
    add(0,1,7, 1,1,0, 2,12);
    add(0,1,7, 0,1,0, 3,13);
    add(0,1,6, 0,0,0, 3,14);
    add(0,1,4, 0,0,0, 3,15);
    add(0,1,1, 0,0,0, 3,16);
    add(0,1,2, 1,0,0, 3,17);
    add(0,1,5, 1,0,0, 3,18);
    // zero in LOCKED twice (with a gap) -> IDLE
    add(0,1,0, 1,1,1, 4,19);
    add(0,0,0, 1,0,0, 4,19);
    add(0,1,0, 0,1,1, 5,20);
    // zero in IDLE, then zero in SEARCH
    add(0,1,0, 0,0,1, 5,21);
    add(0,1,5, 0,0,0, 5,22);
    add(0,1,0, 0,0,1, 5,23);
    add(0,1,3, 0,0,0, 5,24);
    // lock with valid gaps
    add(1,1,7, 0,0,0, 0,0);
    add(0,1,3, 0,0,0, 0,1);
    add(0,0,7, 0,0,0, 0,1);
    add(0,0,7, 0,0,0, 0,1);
    add(0,0,7, 0,0,0, 0,1);
    add(0,1,7, 0,0,0, 0,2);
    add(0,0,1, 0,0,0, 0,2);
    add(0,0,1, 0,0,0, 0,2);
    add(0,0,1, 0,0,0, 0,2);
    add(0,1,6, 0,0,0, 0,3);
    add(0,0,0, 0,0,0, 0,3);
    add(0,1,4, 0,0,0, 0,4);
    add(0,0,0, 0,0,0, 0,4);
    add(0,0,5, 0,0,0, 0,4);
    add(0,1,1, 1,0,0, 0,5);
    add(0,0,3, 1,0,0, 0,5);
    // SEARCH reseed on nonzero mismatch
    add(1,0,0, 0,0,0, 0,0);
    add(0,1,3, 0,0,0, 0,1);
    add(0,1,7, 0,0,0, 0,2);
    add(0,1,5, 0,0,0, 0,3);
    add(0,1,3, 0,0,0, 0,4);
    add(0,1,7, 0,0,0, 0,5);
    add(0,1,6, 0,0,0, 0,6);
    add(0,1,4, 1,0,0, 0,7);
    // two separated errors, then reset mid-LOCKED with valid high
    add(0,1,6, 1,1,0, 1,8);
    add(0,1,2, 1,0,0, 1,9);
    add(0,1,2, 1,1,0, 2,10);
    add(1,1,1, 0,0,0, 0,0);
    add(0,1,4, 0,0,0, 0,1);
    add(0,0,2, 0,0,0, 0,1);

    foreach (tbl[i]) begin
      sb.push_back(tbl[i]);
      drive(tbl[i].rst, tbl[i].valid, tbl[i].data);
      exp_v = sb.pop_front();
      $display("vec %0d rst=%0b valid=%0b data=%0d -> locked=%0b error=%0b zero_err=%0b err_count=%0d sample_count=%0d",
               i, tbl[i].rst, tbl[i].valid, tbl[i].data, locked, error, zero_err, err_count, sample_count);
      check($sformatf("locked[%0d]", i),       int'(locked),       int'(exp_v.locked));
      check($sformatf("error[%0d]", i),        int'(error),        int'(exp_v.error));
      check($sformatf("zero_err[%0d]", i),     int'(zero_err),     int'(exp_v.zero));
      check($sformatf("err_count[%0d]", i),    int'(err_count),    exp_v.ec);
      check($sformatf("sample_count[%0d]", i), int'(sample_count), exp_v.sc);
    end

    // Minimum lock latency from every nonzero seed, bounded wait.
    for (int s = 1; s < 8; s++) begin
      drive(1'b1, 1'b0, 3'd0);
      x = 3'(s);
      n = 0;
      for (int k = 0; k < 12; k++) begin
        drive(1'b0, 1'b1, x);
        n++;
        if (locked) break;
        x = model_next(x);
      end
      $display("seed %0d -> lock after %0d samples, locked=%0b", s, n, locked);
      check($sformatf("lock_latency_seed%0d", s), locked ? n : -1, LOCK_COUNT + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
